rename_scoreboard: RTL
======================

# rename_scoreboard

Parametrised register-alias table and result scoreboard for the decode stage. Successor to the single-width RF-to-ROB mapping, with these additions:
- configurable architectural-register count, ROB depth and number of writeback broadcast channels;
- a per-register "result ready" bit, updated from the writeback buses;
- a one-cycle global flush for taken jumps.

Decode uses it to decide, per source operand, among three sources: the register file, the ROB/bypass network, or a stall.

## Interface
- ARCH_REGS, 32, number of architectural registers; x0 is hard-wired and never renamed.
- ROB_ENTRIES, 16, ROB depth; ROB_ID_W = $clog2(ROB_ENTRIES).
- NUM_WB, 3, writeback broadcast channels (ALU, MEM, MUL order).
- AW = $clog2(ARCH_REGS), derived; CW = $clog2(ARCH_REGS+1), derived.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rs1_idx, rs2_idx  input  AW  source register lookups.
- rs1_busy, rs2_busy  output  1  source is mapped to an uncommitted ROB entry.
- rs1_rob_id, rs2_rob_id  output  ROB_ID_W  mapped ROB entry; valid only when busy.
- rs1_ready, rs2_ready  output  1  mapped entry's result has been broadcast; 0 when not busy.
- rename_valid  input  1  allocate a mapping this cycle.
- rename_rd  input  AW  destination register.
- rename_rob_id  input  ROB_ID_W  ROB entry allocated to the destination.
- commit_valid  input  1  ROB head commits this cycle.
- commit_rd  input  AW  committing destination register.
- commit_rob_id  input  ROB_ID_W  committing ROB entry.
- wb_valid  input  NUM_WB  per-channel result broadcast.
- wb_rob_id  input  NUM_WB*ROB_ID_W  channel i occupies bits [i*ROB_ID_W +: ROB_ID_W].
- flush  input  1  taken jump; discard all speculative mappings.
- busy_count  output  CW  registered count of busy registers.

## Operation
- Per-register state: busy, ready, rob_id. On reset: all bits 0, busy_count 0.
- Lookups are combinational from the registered state:
  - idx 0: busy=0, ready=0, rob_id=0.
  - ready = stored ready OR (busy AND any wb_valid[i] with wb_rob_id[i]==rob_id). This bypasses a same-cycle broadcast.
  - A same-cycle rename or commit does not change lookup outputs. Sources are read before the instruction's own destination is renamed.
- Rename (rename_valid, rename_rd≠0): next state for rd is busy=1, rob_id=rename_rob_id, ready=0. rename_rd=0 is ignored.
- Commit (commit_valid, commit_rd≠0): clear busy and ready only if stored busy AND stored rob_id==commit_rob_id. Otherwise, a newer rename owns the register and the state is untouched.
- Writeback: every busy register whose rob_id matches any valid channel sets ready=1. Multiple channels matching is legal and idempotent.
- Priority per register, highest first:
  1. flush
  2. rename
  3. commit
  4. writeback
- Rename and commit on the same rd in the same cycle: rename wins.
- Flush: all busy/ready cleared next edge, busy_count=0. Same-cycle rename, commit and wb are discarded.
- busy_count: next value = popcount of next busy vector. It is registered and never exceeds ARCH_REGS-1.
- ROB ids wrap modulo ROB_ENTRIES. Uniqueness among in-flight ids is the ROB's responsibility and is not checked here.

## Timing
- Lookup-to-output: combinational, same cycle.
- Rename/commit/wb/flush take effect at the next rising edge; visible on lookups the following cycle.
- Reset assertion mid-operation clears state immediately (asynchronous). Deassertion is synchronised externally; the first edge after deassertion may rename.
- Rename of a register while its previous producer's wb arrives in the same cycle: the new mapping has ready=0.

## Structure
- Shared package: ROB_ID_W derivation helper, AW/CW helpers, WB channel index constants (WB_ALU=0, WB_MEM=1, WB_MUL=2).
- One sub-module: rename_wb_match, a combinational NUM_WB-way comparator returning hit for a given rob_id. It is instantiated once per lookup port and once per table entry (generate loop).

## Test plan
- Reset, then lookup rs1=5, rs2=0 -> busy=0, ready=0 on both; busy_count=0.
- Rename x5→ROB 3, then lookup x5 -> busy=1, rob_id=3, ready=0. Next cycle wb_valid[1] with id 3 -> same-cycle ready=1; ready stays 1 afterwards.
- Rename x5→3, later rename x5→7, then commit x5/3 -> x5 stays busy with rob_id 7; commit x5/7 -> busy=0, busy_count decrements.
- Same-cycle rename x9→4 and commit x9/2 (x9 previously mapped to 2) -> x9 busy, rob_id=4, ready=0.
- Rename x1..x6, then flush with simultaneous rename x7→8 -> all busy=0, busy_count=0, x7 not busy.
- ROB ids 15 then wrap to 0: rename x2→15, x3→0; wb id 0 -> only x3 ready. Also rename_rd=0 -> no state change.

Source files
------------

// File: rtl/rename_scoreboard_pkg.sv
// Shared constants and width helpers for the register-alias table and scoreboard.
package rename_scoreboard_pkg;

  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_MUL = 2;

  function automatic int rob_id_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int idx_width(input int regs);
    return (regs > 1) ? $clog2(regs) : 1;
  endfunction

  function automatic int count_width(input int regs);
    return $clog2(regs + 1);
  endfunction

endpackage

// File: rtl/rename_wb_match.sv
// Combinational comparator: flags when any valid writeback channel carries rob_id.
module rename_wb_match #(
  parameter int NUM_WB   = 3,
  parameter int ROB_ID_W = 4
) (
  input  logic [ROB_ID_W-1:0]        rob_id,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_ID_W-1:0] wb_rob_id,
  output logic                       hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && (wb_rob_id[i*ROB_ID_W +: ROB_ID_W] == rob_id)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/rename_scoreboard.sv
// Register-alias table with per-register result-ready tracking for decode.
module rename_scoreboard
  import rename_scoreboard_pkg::*;
#(
  parameter int ARCH_REGS   = 32,
  parameter int ROB_ENTRIES = 16,
  parameter int NUM_WB      = 3,
  parameter int ROB_ID_W    = rob_id_width(ROB_ENTRIES),
  parameter int AW          = idx_width(ARCH_REGS),
  parameter int CW          = count_width(ARCH_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              rs1_idx,
  input  logic [AW-1:0]              rs2_idx,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [ROB_ID_W-1:0]        rs1_rob_id,
  output logic [ROB_ID_W-1:0]        rs2_rob_id,
  output logic                       rs1_ready,
  output logic                       rs2_ready,
  input  logic                       rename_valid,
  input  logic [AW-1:0]              rename_rd,
  input  logic [ROB_ID_W-1:0]        rename_rob_id,
  input  logic                       commit_valid,
  input  logic [AW-1:0]              commit_rd,
  input  logic [ROB_ID_W-1:0]        commit_rob_id,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_ID_W-1:0] wb_rob_id,
  input  logic                       flush,
  output logic [CW-1:0]              busy_count
);

  logic [ARCH_REGS-1:0] busy_q, busy_d;
  logic [ARCH_REGS-1:0] ready_q, ready_d;
  logic [ROB_ID_W-1:0]  rob_id_q [ARCH_REGS];
  logic [ROB_ID_W-1:0]  rob_id_d [ARCH_REGS];
  logic [ARCH_REGS-1:0] entry_hit;
  logic [CW-1:0]        count_q, count_d;

  for (genvar r = 0; r < ARCH_REGS; r++) begin : g_entry
    rename_wb_match #(.NUM_WB(NUM_WB), .ROB_ID_W(ROB_ID_W)) u_match (
      .rob_id    (rob_id_q[r]),
      .wb_valid  (wb_valid),
      .wb_rob_id (wb_rob_id),
      .hit       (entry_hit[r])
    );
  end

  // Lookups read registered state only; a same-cycle broadcast is bypassed into ready.
  logic [AW-1:0]       lk_idx    [2];
  logic [ROB_ID_W-1:0] lk_stored [2];
  logic [1:0]          lk_hit, lk_busy, lk_ready;
  logic [ROB_ID_W-1:0] lk_rob_id [2];

  assign lk_idx[0] = rs1_idx;
  assign lk_idx[1] = rs2_idx;

  for (genvar p = 0; p < 2; p++) begin : g_lookup
    assign lk_stored[p] = rob_id_q[lk_idx[p]];
    rename_wb_match #(.NUM_WB(NUM_WB), .ROB_ID_W(ROB_ID_W)) u_match (
      .rob_id    (lk_stored[p]),
      .wb_valid  (wb_valid),
      .wb_rob_id (wb_rob_id),
      .hit       (lk_hit[p])
    );
    assign lk_busy[p]   = (lk_idx[p] != '0) && busy_q[lk_idx[p]];
    assign lk_ready[p]  = lk_busy[p] && (ready_q[lk_idx[p]] || lk_hit[p]);
    assign lk_rob_id[p] = lk_busy[p] ? lk_stored[p] : '0;
  end

  assign rs1_busy   = lk_busy[0];
  assign rs2_busy   = lk_busy[1];
  assign rs1_ready  = lk_ready[0];
  assign rs2_ready  = lk_ready[1];
  assign rs1_rob_id = lk_rob_id[0];
  assign rs2_rob_id = lk_rob_id[1];

  // Per-register next state, priority flush > rename > commit > writeback; x0 stays idle.
  always_comb begin
    busy_d   = busy_q;
    ready_d  = ready_q;
    rob_id_d = rob_id_q;
    for (int r = 0; r < ARCH_REGS; r++) begin
      if (r == 0 || flush) begin
        busy_d[r]  = 1'b0;
        ready_d[r] = 1'b0;
      end else if (rename_valid && rename_rd == AW'(r)) begin
        busy_d[r]   = 1'b1;
        ready_d[r]  = 1'b0;
        rob_id_d[r] = rename_rob_id;
      end else if (commit_valid && commit_rd == AW'(r) && busy_q[r] &&
                   rob_id_q[r] == commit_rob_id) begin
        busy_d[r]  = 1'b0;
        ready_d[r] = 1'b0;
      end else if (busy_q[r] && entry_hit[r]) begin
        ready_d[r] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int r = 0; r < ARCH_REGS; r++) count_d = count_d + CW'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      count_q <= '0;
      for (int r = 0; r < ARCH_REGS; r++) rob_id_q[r] <= '0;
    end else begin
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      rob_id_q <= rob_id_d;
    end
  end

  assign busy_count = count_q;

endmodule
